grant_wrr_arbiter: RTL and testbench
====================================

Name: grant_wrr_arbiter

Overview:
- Four-input weighted round-robin arbiter for the TileLink-style grant channel. Multibeat grants are locked until their last beat.
- Per-input weights let managers with bulk data get several consecutive messages before the grant rotates.
- Output is registered, so the path from the input muxes to downstream is timing-isolated. Sits between per-manager grant sources and the client-side grant port.

Parameters:
- N_IN, 4, number of requesters (fixed at 4; io_chosen is 2 bits)
- DATA_W, 64, grant data width
- BEATS, 8, beats per multibeat message (power of 2; beat counter is log2(BEATS) bits)
- WEIGHT_W, 3, width of each per-input weight field

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_in_valid  in  N_IN  per-input valid
- io_in_ready  out  N_IN  per-input ready
- io_in_bits_addr_beat  in  3*N_IN  packed addr_beat, input i at [3i+2:3i]
- io_in_bits_client_xact_id  in  2*N_IN  packed
- io_in_bits_manager_xact_id  in  N_IN  packed
- io_in_bits_is_builtin_type  in  N_IN  packed
- io_in_bits_g_type  in  4*N_IN  packed
- io_in_bits_data  in  DATA_W*N_IN  packed
- cfg_weight  in  WEIGHT_W*N_IN  messages per turn for each input; 0 is treated as 1
- io_out_ready  in  1  downstream ready
- io_out_valid  out  1  registered valid
- io_out_bits_*  out  3/2/1/1/4/DATA_W  registered selected fields
- io_chosen  out  2  registered index of the input that supplied the current output beat

Behaviour:
- Reset (async, immediate): io_out_valid=0; io_out_bits_*=0; io_chosen=0; beat_cnt=0; locked=0; lock_owner=0; cur=N_IN-1; credit=0.
- Output slot:
  - slot_free = !io_out_valid | io_out_ready.
  - Input i fires when io_in_valid[i] & io_in_ready[i].
  - On fire, the fields and i are registered into the output with io_out_valid=1, giving 1-cycle latency.
  - If the slot is free and nothing fires, io_out_valid clears.
- io_in_ready[i] = slot_free & (sel==i). At most one ready is high per cycle. Ready never depends on the same input's valid, except through sel.
- sel, in priority order:
  - locked: lock_owner.
  - else credit!=0 & io_in_valid[cur]: cur.
  - else the first valid input scanning cur+1, cur+2, ... with wrap-around.
  - else no valid input: sel=cur+1 (mod N_IN) and nothing fires.
- Multibeat detection on the firing beat: (is_builtin_type & g_type==5) | (!is_builtin_type & g_type==0).
- Multibeat firing beat:
  - beat_cnt <= beat_cnt+1 (wraps).
  - locked <= (beat_cnt+1 != 0).
  - lock_owner <= sel.
  - The message is complete when beat_cnt+1 wraps to 0, i.e. on the BEATS-th beat.
- A single-beat firing message is complete immediately; beat_cnt and locked are untouched.
- Credit, updated on message completion from input i:
  - i==cur: credit <= credit-1, saturating at 0.
  - i!=cur: cur <= i and credit <= max(weight[i],1)-1.
  - Credit and cur change only at completion, never mid-burst.
- While locked, other inputs are not considered even if lock_owner drops valid. The arbiter waits; there is no timeout.
- Simultaneous events: completion and a new selection in the same cycle use the pre-update cur/credit for that cycle's sel. Updates take effect next cycle.
- io_out_ready low with io_out_valid high holds all outputs stable and all io_in_ready low.
- cfg_weight is sampled only at the completion that switches cur; mid-turn changes take effect on the next switch.
- Reset asserted mid-burst abandons the burst and the lock; arbitration restarts from input 0.

Optional Feature:
- Macro GRANT_ARB_LOCK_CHECK_EN.
- When defined, adds output err_lock (1 bit, sticky, cleared only by reset). It sets when either:
  - locked and !io_in_valid[lock_owner] while slot_free; or
  - a firing multibeat beat's addr_beat != beat_cnt.
- err_lock does not alter arbitration.
- Without the macro the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Single-beat RR, weights all 1: inputs 0..3 always valid (single-beat, builtin g_type=0), io_out_ready=1 -> io_chosen sequence 0,1,2,3,0,...; one output beat per cycle after 1-cycle latency.
- Weights {3,1,1,1}, all valid with single-beat messages -> io_chosen 0,0,0,1,2,3,0,0,0,...
- Lock: input 1 sends an 8-beat builtin g_type=5 message while input 2 is valid -> 8 consecutive io_chosen=1 beats with addr_beat 0..7, then input 2 is granted; io_in_ready[2]=0 throughout the burst.
- Backpressure: io_out_ready=0 for 5 cycles mid-burst -> outputs held stable, all io_in_ready=0, no beats lost or duplicated, beat order preserved after release.
- Async reset asserted at beat 4 of a burst -> io_out_valid drops without a clock edge; after release, input 0 is granted first and the new burst begins with beat_cnt=0.
- GRANT_ARB_LOCK_CHECK_EN: owner drops valid at beat 3 -> err_lock=1 next cycle and stays 1 until reset; without the macro the same stimulus compiles and arbitrates identically.

Source files
------------

// File: rtl/grant_wrr_arbiter.sv
// Four-input weighted round-robin arbiter for the grant channel, with multibeat locking and a registered output.
// Ports:
//   clk, reset (async, active high)
//   io_in_valid/ready     : per-input handshake
//   io_in_bits_*          : packed per-input fields
//   cfg_weight            : messages per turn for each input (0 counts as 1)
//   io_out_valid/ready    : registered output handshake
//   io_out_bits_*         : registered fields
//   io_chosen             : registered source index
// Optional: define GRANT_ARB_LOCK_CHECK_EN to add the sticky err_lock output.
module grant_wrr_arbiter #(
  parameter int N_IN     = 4,
  parameter int DATA_W   = 64,
  parameter int BEATS    = 8,
  parameter int WEIGHT_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IN-1:0]            io_in_valid,
  output logic [N_IN-1:0]            io_in_ready,
  input  logic [3*N_IN-1:0]          io_in_bits_addr_beat,
  input  logic [2*N_IN-1:0]          io_in_bits_client_xact_id,
  input  logic [N_IN-1:0]            io_in_bits_manager_xact_id,
  input  logic [N_IN-1:0]            io_in_bits_is_builtin_type,
  input  logic [4*N_IN-1:0]          io_in_bits_g_type,
  input  logic [DATA_W*N_IN-1:0]     io_in_bits_data,
  input  logic [WEIGHT_W*N_IN-1:0]   cfg_weight,
  input  logic                       io_out_ready,
  output logic                       io_out_valid,
  output logic [2:0]                 io_out_bits_addr_beat,
  output logic [1:0]                 io_out_bits_client_xact_id,
  output logic                       io_out_bits_manager_xact_id,
  output logic                       io_out_bits_is_builtin_type,
  output logic [3:0]                 io_out_bits_g_type,
  output logic [DATA_W-1:0]          io_out_bits_data,
  output logic [1:0]                 io_chosen
`ifdef GRANT_ARB_LOCK_CHECK_EN
  ,
  output logic                       err_lock
`endif
);

  localparam int BW = $clog2(BEATS);

  logic [1:0]          cur_q, cur_d;
  logic [1:0]          own_q, own_d;
  logic [WEIGHT_W-1:0] cred_q, cred_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                lock_q, lock_d;

  logic                vld_q;
  logic [2:0]          ab_q;
  logic [1:0]          cx_q;
  logic                mx_q;
  logic                bi_q;
  logic [3:0]          gt_q;
  logic [DATA_W-1:0]   dt_q;
  logic [1:0]          ch_q;

  logic [1:0]          sel, scan, idx;
  logic                found;
  logic                slot_free, fire, mb, done;
  logic [BW-1:0]       beat_inc;
  logic [WEIGHT_W-1:0] w_sel;

  logic [2:0]          s_ab;
  logic [1:0]          s_cx;
  logic                s_mx;
  logic                s_bi;
  logic [3:0]          s_gt;
  logic [DATA_W-1:0]   s_dt;

  assign slot_free = !vld_q || io_out_ready;

  // Round-robin scan starting after cur; cur itself is visited last.
  always_comb begin
    scan  = cur_q + 2'd1;
    found = 1'b0;
    idx   = cur_q;
    for (int k = 1; k <= N_IN; k++) begin
      idx = cur_q + 2'(k);
      if (!found && io_in_valid[idx]) begin
        scan  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel = scan;
    unique case (1'b1)
      lock_q:
        sel = own_q;
      !lock_q && (cred_q != '0) && io_in_valid[cur_q]:
        sel = cur_q;
      default:
        sel = scan;
    endcase
  end

  assign s_ab = io_in_bits_addr_beat[int'(sel)*3 +: 3];
  assign s_cx = io_in_bits_client_xact_id[int'(sel)*2 +: 2];
  assign s_mx = io_in_bits_manager_xact_id[sel];
  assign s_bi = io_in_bits_is_builtin_type[sel];
  assign s_gt = io_in_bits_g_type[int'(sel)*4 +: 4];
  assign s_dt = io_in_bits_data[int'(sel)*DATA_W +: DATA_W];
  assign w_sel = cfg_weight[int'(sel)*WEIGHT_W +: WEIGHT_W];

  assign io_in_ready = slot_free ? (N_IN'(1) << sel) : '0;
  assign fire        = slot_free && io_in_valid[sel];

  assign mb       = (s_bi && s_gt == 4'd5) || (!s_bi && s_gt == 4'd0);
  assign beat_inc = beat_q + BW'(1);
  // A message ends on a single beat or when the beat counter wraps.
  assign done     = fire && (!mb || beat_inc == '0);

  always_comb begin
    beat_d = beat_q;
    lock_d = lock_q;
    own_d  = own_q;
    cur_d  = cur_q;
    cred_d = cred_q;
    if (fire && mb) begin
      beat_d = beat_inc;
      lock_d = (beat_inc != '0);
      own_d  = sel;
    end
    if (done) begin
      if (sel == cur_q) begin
        cred_d = (cred_q == '0) ? '0 : cred_q - WEIGHT_W'(1);
      end else begin
        cur_d  = sel;
        cred_d = (w_sel == '0) ? '0 : w_sel - WEIGHT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q  <= 2'(N_IN - 1);
      own_q  <= '0;
      cred_q <= '0;
      beat_q <= '0;
      lock_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      own_q  <= own_d;
      cred_q <= cred_d;
      beat_q <= beat_d;
      lock_q <= lock_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      ab_q  <= '0;
      cx_q  <= '0;
      mx_q  <= 1'b0;
      bi_q  <= 1'b0;
      gt_q  <= '0;
      dt_q  <= '0;
      ch_q  <= '0;
    end else if (fire) begin
      vld_q <= 1'b1;
      ab_q  <= s_ab;
      cx_q  <= s_cx;
      mx_q  <= s_mx;
      bi_q  <= s_bi;
      gt_q  <= s_gt;
      dt_q  <= s_dt;
      ch_q  <= sel;
    end else if (slot_free) begin
      vld_q <= 1'b0;
    end
  end

  assign io_out_valid                = vld_q;
  assign io_out_bits_addr_beat       = ab_q;
  assign io_out_bits_client_xact_id  = cx_q;
  assign io_out_bits_manager_xact_id = mx_q;
  assign io_out_bits_is_builtin_type = bi_q;
  assign io_out_bits_g_type          = gt_q;
  assign io_out_bits_data            = dt_q;
  assign io_chosen                   = ch_q;

`ifdef GRANT_ARB_LOCK_CHECK_EN
  logic err_q, err_d;

  // Owner stalling a locked burst, or a beat arriving out of order.
  always_comb begin
    err_d = err_q;
    if (lock_q && !io_in_valid[own_q] && slot_free)
      err_d = 1'b1;
    if (fire && mb && (32'(s_ab) != 32'(beat_q)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_lock = err_q;
`endif

endmodule

// File: tb/tb_grant_wrr_arbiter.sv
// Scoreboard bench for grant_wrr_arbiter: per-input source queues drive the
// inputs, expected output beats are queued at load time and popped on handshake.
module tb_grant_wrr_arbiter;

  typedef struct packed {
    logic        bi;
    logic [3:0]  gt;
    logic [2:0]  ab;
    logic [63:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   in_valid;
  logic [3:0]   io_in_ready;
  logic [11:0]  ab_v;
  logic [7:0]   cx_v;
  logic [3:0]   mx_v;
  logic [3:0]   bi_v;
  logic [15:0]  gt_v;
  logic [255:0] dt_v;
  logic [11:0]  w_v;
  logic         out_ready;
  logic         io_out_valid;
  logic [2:0]   o_ab;
  logic [1:0]   o_cx;
  logic         o_mx;
  logic         o_bi;
  logic [3:0]   o_gt;
  logic [63:0]  o_dt;
  logic [1:0]   io_chosen;
`ifdef GRANT_ARB_LOCK_CHECK_EN
  logic         err_lock;
`endif

  grant_wrr_arbiter dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_in_valid                 (in_valid),
    .io_in_ready                 (io_in_ready),
    .io_in_bits_addr_beat        (ab_v),
    .io_in_bits_client_xact_id   (cx_v),
    .io_in_bits_manager_xact_id  (mx_v),
    .io_in_bits_is_builtin_type  (bi_v),
    .io_in_bits_g_type           (gt_v),
    .io_in_bits_data             (dt_v),
    .cfg_weight                  (w_v),
    .io_out_ready                (out_ready),
    .io_out_valid                (io_out_valid),
    .io_out_bits_addr_beat       (o_ab),
    .io_out_bits_client_xact_id  (o_cx),
    .io_out_bits_manager_xact_id (o_mx),
    .io_out_bits_is_builtin_type (o_bi),
    .io_out_bits_g_type          (o_gt),
    .io_out_bits_data            (o_dt),
    .io_chosen                   (io_chosen)
`ifdef GRANT_ARB_LOCK_CHECK_EN
    ,
    .err_lock                    (err_lock)
`endif
  );

  beat_t       srcq[4][$];
  logic [76:0] expq[$];
  logic [3:0]  drop;
  logic [3:0]  fired;
  int          nfire[4];
  int          nout;
  int          seqn;
  int          errors = 0;
  int          checks = 0;
  bit          mode_rr, mode_lock, mode_stall, mode_drop;
  int          stall_cnt, drop_cnt;
  logic [77:0] snap;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [76:0] pk(input logic [1:0] ch, input beat_t b);
    return {ch, b.ab, ch, ch[0], b.bi, b.gt, b.d};
  endfunction

  function automatic logic [76:0] got_now();
    return {io_chosen, o_ab, o_cx, o_mx, o_bi, o_gt, o_dt};
  endfunction

  task automatic drive();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b = '0;
      if (srcq[i].size() != 0) b = srcq[i][0];
      in_valid[i]     = (srcq[i].size() != 0) && !drop[i];
      ab_v[3*i +: 3]  = b.ab;
      cx_v[2*i +: 2]  = 2'(i);
      mx_v[i]         = i[0];
      bi_v[i]         = b.bi;
      gt_v[4*i +: 4]  = b.gt;
      dt_v[64*i +: 64] = b.d;
    end
  endtask

  task automatic load_single(input int i, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.bi = 1'b1;
      b.gt = 4'd0;
      b.ab = 3'd0;
      b.d  = {32'(i), 32'(seqn)};
      seqn++;
      srcq[i].push_back(b);
    end
  endtask

  task automatic load_burst(input int i, input bit bi);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.bi = bi;
      b.gt = bi ? 4'd5 : 4'd0;
      b.ab = 3'(k);
      b.d  = {32'(i), 32'(seqn)};
      seqn++;
      srcq[i].push_back(b);
    end
  endtask

  task automatic expect_n(input int i, input int from, input int n);
    for (int j = from; j < from + n; j++)
      expq.push_back(pk(2'(i), srcq[i][j]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      srcq[i].delete();
      nfire[i] = 0;
    end
    expq.delete();
    drop = '0;
    out_ready = 1'b1;
    mode_rr = 0; mode_lock = 0; mode_stall = 0; mode_drop = 0;
    stall_cnt = 0; drop_cnt = 0; nout = 0;
    w_v = {3'd1, 3'd1, 3'd1, 3'd1};
    drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic sample();
    logic [76:0] e;
    @(negedge clk);
    fired = in_valid & io_in_ready;
    if (io_out_valid && out_ready) begin
      chk("sb_nonempty", 128'(expq.size() != 0), 128'(1));
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("beat", 128'(got_now()), 128'(e));
      end
      nout++;
    end
    if (mode_rr && nout >= 1 && expq.size() != 0)
      chk("rr_every_cycle", 128'(io_out_valid), 128'(1));
    if (mode_lock && srcq[1].size() != 0)
      chk("rdy2_locked", 128'(io_in_ready[2]), 128'(0));
    if (mode_stall && !out_ready) begin
      chk("stall_rdy", 128'(io_in_ready), 128'(0));
      if (stall_cnt == 1) snap = {io_out_valid, got_now()};
      else chk("stall_hold", 128'({io_out_valid, got_now()}), 128'(snap));
    end
    if (mode_drop && drop_cnt > 0 && drop_cnt <= 3 && drop[0])
      chk("rdy1_drop", 128'(io_in_ready[1]), 128'(0));
`ifdef GRANT_ARB_LOCK_CHECK_EN
    if (mode_drop) begin
      if (drop_cnt <= 1) chk("err_clear", 128'(err_lock), 128'(0));
      else               chk("err_set", 128'(err_lock), 128'(1));
    end
`endif
  endtask

  task automatic advance();
    beat_t b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fired[i]) begin
        b = srcq[i].pop_front();
        nfire[i]++;
      end
    end
    if (mode_stall) begin
      if (nout == 3 && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
    if (mode_drop) begin
      if (nfire[0] == 3 && drop_cnt < 3) begin
        drop[0] = 1'b1;
        drop_cnt++;
      end else begin
        drop[0] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic run(input int limit);
    for (int c = 0; c < limit && expq.size() != 0; c++) begin
      sample();
      advance();
    end
    chk("drain", 128'(expq.size()), 128'(0));
  endtask

  initial begin
    seqn = 0;
    drop = '0;
    #1;
    chk("rst_vld", 128'(io_out_valid), 128'(0));
    do_reset();

    @(negedge clk);
    chk("rst_vld_idle", 128'(io_out_valid), 128'(0));
    chk("rst_bits", 128'({io_chosen, got_now()}), 128'(0));
    chk("rst_ready", 128'(io_in_ready), 128'(4'b0001));

    // round robin, weights 1
    do_reset();
    for (int i = 0; i < 4; i++) load_single(i, 3);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) expect_n(i, r, 1);
    mode_rr = 1;
    drive();
    run(100);

    // weights {3,1,1,1}
    do_reset();
    w_v = {3'd1, 3'd1, 3'd1, 3'd3};
    load_single(0, 6);
    for (int i = 1; i < 4; i++) load_single(i, 2);
    expect_n(0, 0, 3);
    for (int i = 1; i < 4; i++) expect_n(i, 0, 1);
    expect_n(0, 3, 3);
    for (int i = 1; i < 4; i++) expect_n(i, 1, 1);
    drive();
    run(100);

    // weight 0 acts as 1
    do_reset();
    w_v = '0;
    for (int i = 0; i < 4; i++) load_single(i, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) expect_n(i, r, 1);
    drive();
    run(100);

    // lock: input 1 burst while input 2 waits
    do_reset();
    load_burst(1, 1'b1);
    load_single(2, 1);
    expect_n(1, 0, 8);
    expect_n(2, 0, 1);
    mode_lock = 1;
    drive();
    run(100);

    // backpressure mid-burst, non-builtin g_type 0 burst
    do_reset();
    load_burst(0, 1'b0);
    load_single(3, 1);
    expect_n(0, 0, 8);
    expect_n(3, 0, 1);
    mode_stall = 1;
    drive();
    run(100);
    chk("stall_cycles", 128'(stall_cnt), 128'(5));

    // async reset mid-burst
    do_reset();
    load_burst(0, 1'b1);
    expect_n(0, 0, 8);
    drive();
    for (int c = 0; c < 50 && nout < 4; c++) begin
      sample();
      advance();
    end
    chk("pre_rst_vld", 128'(io_out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_vld", 128'(io_out_valid), 128'(0));
    chk("async_rst_bits", 128'(got_now()), 128'(0));
    for (int i = 0; i < 4; i++) srcq[i].delete();
    expq.delete();
    drive();
    @(posedge clk);
    #1 reset = 1'b0;
    nout = 0;
    load_burst(2, 1'b1);
    load_burst(0, 1'b1);
    expect_n(0, 0, 8);
    expect_n(2, 0, 8);
    drive();
    run(100);

    // owner drops valid mid-burst
    do_reset();
    load_burst(0, 1'b1);
    load_single(1, 1);
    expect_n(0, 0, 8);
    expect_n(1, 0, 1);
    mode_drop = 1;
    drive();
    run(100);
    chk("drop_cycles", 128'(drop_cnt), 128'(3));
`ifdef GRANT_ARB_LOCK_CHECK_EN
    chk("err_sticky", 128'(err_lock), 128'(1));
    do_reset();
    @(negedge clk);
    chk("err_rst", 128'(err_lock), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
